// File: rtl/baccarat_sequencer.sv
// Baccarat deal/third-card control FSM with registered load strobes.
// Optional auto-restart after a RESULT dwell: BACCARAT_AUTO_RESTART_EN.
//
// Ports:
//   slow_clock        sole clock, rising edge
//   resetb            synchronous active-low reset
//   pscore, dscore    live hand scores from the datapath (0-9)
//   pcard3            player third card rank (0 none, 1-13 A..K)
//   load_pcard1..3    one-cycle player card load strobes
//   load_dcard1..3    one-cycle dealer card load strobes
//   player_win_light  player wins or ties (RESULT only)
//   dealer_win_light  dealer wins or ties (RESULT only)
//   clear_hand        one-cycle hand clear pulse (auto-restart only)
//
// Parameter (auto-restart build only):
//   HOLD_CYCLES       RESULT dwell before restart, >= 1
module baccarat_sequencer
`ifdef BACCARAT_AUTO_RESTART_EN
#(
  parameter int HOLD_CYCLES = 32
)
`endif
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       clear_hand
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    DEAL_P1   = 4'd1,
    DEAL_D1   = 4'd2,
    DEAL_P2   = 4'd3,
    DEAL_D2   = 4'd4,
    CHECK_NAT = 4'd5,
    DEAL_P3   = 4'd6,
    CHECK_D3  = 4'd7,
    DEAL_D3   = 4'd8,
    RESULT    = 4'd9,
    CLEAR     = 4'd10
  } state_t;

  state_t state;
  state_t nxt;

  // Third card value: tens and faces count as zero.
  logic [3:0] v;
  logic       d3_draw;
  logic       natural;

  assign v = (pcard3 >= 4'd10) ? 4'd0 : pcard3;

  // Out-of-range scores (10-15) land in the natural branch.
  assign natural = (pscore >= 4'd8) || (dscore >= 4'd8);

  always_comb begin
    d3_draw = 1'b0;
    unique case (dscore)
      4'd0, 4'd1, 4'd2:
        d3_draw = 1'b1;
      4'd3:
        d3_draw = (v != 4'd8);
      4'd4:
        d3_draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:
        d3_draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:
        d3_draw = (v >= 4'd6) && (v <= 4'd7);
      default:
        d3_draw = 1'b0;
    endcase
  end

`ifdef BACCARAT_AUTO_RESTART_EN
  localparam int CW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          hold_done;

  assign hold_done = (cnt == LAST);
`endif

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = DEAL_P1;
      DEAL_P1: nxt = DEAL_D1;
      DEAL_D1: nxt = DEAL_P2;
      DEAL_P2: nxt = DEAL_D2;
      DEAL_D2: nxt = CHECK_NAT;
      CHECK_NAT: begin
        if (natural)
          nxt = RESULT;
        else if (pscore <= 4'd5)
          nxt = DEAL_P3;
        else if (dscore <= 4'd5)
          nxt = DEAL_D3;
        else
          nxt = RESULT;
      end
      DEAL_P3: nxt = CHECK_D3;
      CHECK_D3:
        nxt = d3_draw ? DEAL_D3 : RESULT;
      DEAL_D3: nxt = RESULT;
`ifdef BACCARAT_AUTO_RESTART_EN
      RESULT:
        nxt = hold_done ? CLEAR : RESULT;
      CLEAR:   nxt = IDLE;
`else
      RESULT:  nxt = RESULT;
      CLEAR:   nxt = IDLE;
`endif
      default: nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so each one is
  // high exactly while the FSM sits in its DEAL state.
  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      state       <= IDLE;
      load_pcard1 <= 1'b0;
      load_dcard1 <= 1'b0;
      load_pcard2 <= 1'b0;
      load_dcard2 <= 1'b0;
      load_pcard3 <= 1'b0;
      load_dcard3 <= 1'b0;
`ifdef BACCARAT_AUTO_RESTART_EN
      cnt         <= '0;
      clear_hand  <= 1'b0;
`endif
    end else begin
      state       <= nxt;
      load_pcard1 <= (nxt == DEAL_P1);
      load_dcard1 <= (nxt == DEAL_D1);
      load_pcard2 <= (nxt == DEAL_P2);
      load_dcard2 <= (nxt == DEAL_D2);
      load_pcard3 <= (nxt == DEAL_P3);
      load_dcard3 <= (nxt == DEAL_D3);
`ifdef BACCARAT_AUTO_RESTART_EN
      clear_hand  <= (nxt == CLEAR);
      if (state != RESULT)
        cnt <= '0;
      else if (!hold_done)
        cnt <= cnt + 1'b1;
`endif
    end
  end

`ifndef BACCARAT_AUTO_RESTART_EN
  assign clear_hand = 1'b0;
`endif

  // Lights follow the live scores while in RESULT.
  assign player_win_light =
    (state == RESULT) && (pscore >= dscore);
  assign dealer_win_light =
    (state == RESULT) && (dscore >= pscore);

endmodule

// File: tb/tb_baccarat_sequencer.sv
// Directed bench for baccarat_sequencer.
// Checks strobe timing, third-card rules, lights and restart.
module tb_baccarat_sequencer;

  logic       clk;
  logic       resetb;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       lp1, lp2, lp3;
  logic       ld1, ld2, ld3;
  logic       pwin, dwin;
  logic       clr;

  int checks;
  int failures;

`ifdef BACCARAT_AUTO_RESTART_EN
  baccarat_sequencer #(.HOLD_CYCLES(4)) dut (
`else
  baccarat_sequencer dut (
`endif
    .slow_clock       (clk),
    .resetb           (resetb),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (lp1),
    .load_pcard2      (lp2),
    .load_pcard3      (lp3),
    .load_dcard1      (ld1),
    .load_dcard2      (ld2),
    .load_dcard3      (ld3),
    .player_win_light (pwin),
    .dealer_win_light (dwin),
    .clear_hand       (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe order P1 D1 P2 D2 P3 D3, MSB first.
  localparam logic [5:0] S_P1 = 6'h20;
  localparam logic [5:0] S_D1 = 6'h10;
  localparam logic [5:0] S_P2 = 6'h08;
  localparam logic [5:0] S_D2 = 6'h04;
  localparam logic [5:0] S_P3 = 6'h02;
  localparam logic [5:0] S_D3 = 6'h01;
  localparam logic [5:0] S_NO = 6'h00;

  function automatic logic [5:0] strb();
    return {lp1, ld1, lp2, ld2, lp3, ld3};
  endfunction

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_lights(input string tag,
                            input logic p,
                            input logic d);
    chk(tag, {6'd0, pwin, dwin}, {6'd0, p, d});
  endtask

  // Reset for one edge, then deal through CHECK_NAT (after E4).
  task automatic deal4(input string tag);
    resetb = 1'b0;
    tick();
    chk({tag, "_rst"}, {2'd0, strb()}, {2'd0, S_NO});
    chk_lights({tag, "_rstl"}, 1'b0, 1'b0);
    resetb = 1'b1;
    tick();
    chk({tag, "_p1"}, {2'd0, strb()}, {2'd0, S_P1});
    tick();
    chk({tag, "_d1"}, {2'd0, strb()}, {2'd0, S_D1});
    tick();
    chk({tag, "_p2"}, {2'd0, strb()}, {2'd0, S_P2});
    tick();
    chk({tag, "_d2"}, {2'd0, strb()}, {2'd0, S_D2});
    tick();
    chk({tag, "_cn"}, {2'd0, strb()}, {2'd0, S_NO});
    chk_lights({tag, "_cnl"}, 1'b0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetb   = 1'b0;
    pscore   = 4'd0;
    dscore   = 4'd0;
    pcard3   = 4'd0;
    tick();
    chk("reset_strobes", {2'd0, strb()}, 8'h00);
    chk_lights("reset_lights", 1'b0, 1'b0);
    chk("reset_clear", {7'd0, clr}, 8'h00);

    // 1: natural 8 vs 0
    pscore = 4'd8;
    dscore = 4'd0;
    deal4("nat");
    tick();
    chk("nat_e5", {2'd0, strb()}, {2'd0, S_NO});
    chk_lights("nat_l", 1'b1, 1'b0);
    tick();
    chk("nat_e6", {2'd0, strb()}, {2'd0, S_NO});
    chk_lights("nat_l6", 1'b1, 1'b0);

    // 2: both draw, tie 7-7
    pscore = 4'd5;
    dscore = 4'd3;
    pcard3 = 4'd2;
    deal4("both");
    tick();
    chk("both_p3", {2'd0, strb()}, {2'd0, S_P3});
    tick();
    chk("both_cd3", {2'd0, strb()}, {2'd0, S_NO});
    tick();
    chk("both_d3", {2'd0, strb()}, {2'd0, S_D3});
    pscore = 4'd7;
    dscore = 4'd7;
    tick();
    chk("both_res", {2'd0, strb()}, {2'd0, S_NO});
    chk_lights("both_tie", 1'b1, 1'b1);

    // 3a: dealer 3 stands on an 8
    pscore = 4'd4;
    dscore = 4'd3;
    pcard3 = 4'd8;
    deal4("st8");
    tick();
    chk("st8_p3", {2'd0, strb()}, {2'd0, S_P3});
    tick();
    tick();
    chk("st8_e7", {2'd0, strb()}, {2'd0, S_NO});
    chk_lights("st8_l", 1'b1, 1'b0);

    // 3b: queen counts as 0, dealer 3 draws
    pcard3 = 4'd12;
    deal4("q");
    tick();
    tick();
    tick();
    chk("q_e7", {2'd0, strb()}, {2'd0, S_D3});

    // Dealer 6 draws on a 6 and stands on a 5
    pscore = 4'd2;
    dscore = 4'd6;
    pcard3 = 4'd6;
    deal4("d6");
    tick();
    tick();
    tick();
    chk("d6_v6", {2'd0, strb()}, {2'd0, S_D3});
    pcard3 = 4'd5;
    deal4("d6s");
    tick();
    tick();
    tick();
    chk("d6_v5", {2'd0, strb()}, {2'd0, S_NO});
    chk_lights("d6s_l", 1'b0, 1'b1);

    // 4: player stands on 6, dealer 4 draws
    pscore = 4'd6;
    dscore = 4'd4;
    pcard3 = 4'd0;
    deal4("ps");
    tick();
    chk("ps_e5", {2'd0, strb()}, {2'd0, S_D3});
    tick();
    chk("ps_e6", {2'd0, strb()}, {2'd0, S_NO});
    chk_lights("ps_l", 1'b1, 1'b0);

    // Both stand 7 vs 6
    pscore = 4'd7;
    dscore = 4'd6;
    deal4("bs");
    tick();
    chk("bs_e5", {2'd0, strb()}, {2'd0, S_NO});
    chk_lights("bs_l", 1'b1, 1'b0);

    // Out-of-range dealer score 12 is a natural
    pscore = 4'd3;
    dscore = 4'd12;
    deal4("oor");
    tick();
    chk("oor_e5", {2'd0, strb()}, {2'd0, S_NO});
    chk_lights("oor_l", 1'b0, 1'b1);

    // 5: reset while in DEAL_P2
    resetb = 1'b0;
    tick();
    resetb = 1'b1;
    tick();
    chk("mr_p1", {2'd0, strb()}, {2'd0, S_P1});
    tick();
    tick();
    chk("mr_p2", {2'd0, strb()}, {2'd0, S_P2});
    resetb = 1'b0;
    tick();
    chk("mr_drop", {2'd0, strb()}, {2'd0, S_NO});
    resetb = 1'b1;
    tick();
    chk("mr_again", {2'd0, strb()}, {2'd0, S_P1});

`ifdef BACCARAT_AUTO_RESTART_EN
    // 6: four RESULT cycles, one CLEAR, IDLE, new hand
    pscore = 4'd9;
    dscore = 4'd1;
    deal4("ar");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_lights("ar_hold", 1'b1, 1'b0);
      chk("ar_noclr", {7'd0, clr}, 8'h00);
    end
    tick();
    chk("ar_clr", {7'd0, clr}, 8'h01);
    chk_lights("ar_clrl", 1'b0, 1'b0);
    tick();
    chk("ar_idle", {7'd0, clr}, 8'h00);
    chk("ar_idles", {2'd0, strb()}, {2'd0, S_NO});
    tick();
    chk("ar_p1", {2'd0, strb()}, {2'd0, S_P1});
`else
    // RESULT is absorbing; clear_hand never rises
    pscore = 4'd9;
    dscore = 4'd1;
    deal4("ab");
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_lights("ab_hold", 1'b1, 1'b0);
      chk("ab_clr", {7'd0, clr}, 8'h00);
    end
    chk("ab_strb", {2'd0, strb()}, {2'd0, S_NO});
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
